modn_sequence_counter: RTL and testbench

//   Parametrised sequence counter for the control unit: generates the one-hot cycle strobes that step a

---
 rtl/modn_sequence_counter_pkg.sv | 17 +
 rtl/modn_sequence_counter_if.sv | 31 +++
 rtl/modn_sequence_counter_onehot_decoder.sv | 13 +
 rtl/modn_sequence_counter.sv | 68 ++++++
 tb/tb_modn_sequence_counter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/modn_sequence_counter_pkg.sv
// Shared definitions for the sequence counter and other control blocks.
package modn_sequence_counter_pkg;

  // Default maximum sequence length
  localparam int N_MAX_DEFAULT = 5;

  // mode input encoding
  localparam logic MODE_CONT   = 1'b0;  // wrap and keep running
  localparam logic MODE_SINGLE = 1'b1;  // stop after the last cycle

  // Run flag
  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

endpackage

// File: rtl/modn_sequence_counter_if.sv
// Control-side bus of the sequence counter: request/stall/config in, strobes and status out.
interface modn_sequence_counter_if
  import modn_sequence_counter_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEFAULT
);
  localparam int CW = $clog2(N_MAX);

  logic             begin_sig;
  logic             end_sig;
  logic             stall;
  logic             mode;
  logic [CW-1:0]    last;
  logic [N_MAX-1:0] cycle;
  logic [CW-1:0]    count;
  logic             active;
  logic             wrap;
  logic             done;

  // Control FSM side
  modport master (
    output begin_sig, end_sig, stall, mode, last,
    input  cycle, count, active, wrap, done
  );

  // Counter side
  modport slave (
    input  begin_sig, end_sig, stall, mode, last,
    output cycle, count, active, wrap, done
  );
endinterface

// File: rtl/modn_sequence_counter_onehot_decoder.sv
// Binary index -> one-hot strobe decode; purely combinational, reusable by other control blocks.
module modn_sequence_counter_onehot_decoder #(
  parameter int N  = 5,
  parameter int CW = $clog2(N)
) (
  input  logic [CW-1:0] count,
  output logic [N-1:0]  cycle
);
  // One comparator per output bit
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign cycle[i] = (count == CW'(i));
  end
endmodule

// File: rtl/modn_sequence_counter.sv
// N-cycle sequence counter: run flag, count register, terminal compare and wrap/done pulses.
module modn_sequence_counter
  import modn_sequence_counter_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  modn_sequence_counter_if.slave  bus
);
  localparam int            CW       = $clog2(N_MAX);
  localparam logic [CW-1:0] TERM_MAX = CW'(N_MAX - 1);

  run_state_e    run;
  logic [CW-1:0] count;
  logic          wrap;
  logic          done;
  logic [CW-1:0] term;
  logic          at_term;

  // Runtime terminal count clamped to the physical range; >= compare means a term
  // lowered below the current count still wraps on the next advance.
  assign term    = (bus.last > TERM_MAX) ? TERM_MAX : bus.last;
  assign at_term = (count >= term);

  // Run flag, count and pulse registers; end_sig has priority and freezes the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      run   <= RUN_IDLE;
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      if (bus.end_sig) begin
        run  <= RUN_IDLE;
        done <= (run == RUN_ACTIVE);
      end else if (run == RUN_IDLE) begin
        if (bus.begin_sig) begin
          run   <= RUN_ACTIVE;
          count <= '0;
        end
      end else if (!bus.stall) begin
        if (at_term) begin
          count <= '0;
          wrap  <= 1'b1;
          if (bus.mode == MODE_SINGLE) begin
            run  <= RUN_IDLE;
            done <= 1'b1;
          end
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  modn_sequence_counter_onehot_decoder #(.N(N_MAX), .CW(CW)) u_dec (
    .count (count),
    .cycle (bus.cycle)
  );

  assign bus.count  = count;
  assign bus.active = (run == RUN_ACTIVE);
  assign bus.wrap   = wrap;
  assign bus.done   = done;
endmodule

// File: tb/tb_modn_sequence_counter.sv
// Bench for modn_sequence_counter: directed scenarios then random traffic against a rule-level model.
module tb_modn_sequence_counter;
  localparam int N  = 5;
  localparam int CW = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modn_sequence_counter_if #(.N_MAX(N)) bus();

  modn_sequence_counter #(.N_MAX(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: run flag, cycle index, last pulses
  int m_run  = 0;
  int m_cnt  = 0;
  int m_wrap = 0;
  int m_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict from the rules, then compare every output
  task automatic cyc(input string tag);
    int term, adv, n_run, n_cnt, n_wrap, n_done;
    term = (int'(bus.last) > N - 1) ? N - 1 : int'(bus.last);
    if (!reset) begin
      n_run = 0; n_cnt = 0; n_wrap = 0; n_done = 0;
    end else begin
      adv    = (m_run != 0) && !bus.end_sig && !bus.stall;
      n_wrap = adv && (m_cnt >= term);
      if (adv) n_cnt = n_wrap ? 0 : m_cnt + 1;
      else if (!m_run && bus.begin_sig && !bus.end_sig) n_cnt = 0;
      else n_cnt = m_cnt;
      if (bus.end_sig) n_run = 0;
      else if (!m_run && bus.begin_sig) n_run = 1;
      else if (n_wrap && bus.mode) n_run = 0;
      else n_run = m_run;
      n_done = m_run && !n_run;
    end
    @(posedge clk);
    #1;
    m_run = n_run; m_cnt = n_cnt; m_wrap = n_wrap; m_done = n_done;
    chk({tag, ".count"},  32'(bus.count),  32'(m_cnt));
    chk({tag, ".cycle"},  32'(bus.cycle),  32'(1) << m_cnt);
    chk({tag, ".active"}, 32'(bus.active), 32'(m_run));
    chk({tag, ".wrap"},   32'(bus.wrap),   32'(m_wrap));
    chk({tag, ".done"},   32'(bus.done),   32'(m_done));
  endtask

  // Advance until the model reaches a given index, bounded
  task automatic seek(input int target);
    for (int i = 0; i < 20 && m_cnt != target; i++) cyc("seek");
    chk("seek_reached", 32'(bus.count), 32'(target));
  endtask

  initial begin
    reset = 1'b0;
    bus.begin_sig = 1'b0; bus.end_sig = 1'b0; bus.stall = 1'b0;
    bus.mode = 1'b0; bus.last = CW'(4);

    // 1: reset then idle
    cyc("t1_rst"); cyc("t1_rst");
    reset = 1'b1;
    cyc("t1_idle");
    chk("t1_cycle", 32'(bus.cycle), 32'h1);
    chk("t1_active", 32'(bus.active), 32'h0);

    // 2: continuous full-length sequence
    bus.begin_sig = 1'b1; cyc("t2_begin"); bus.begin_sig = 1'b0;
    chk("t2_start_cnt", 32'(bus.count), 32'h0);
    chk("t2_start_act", 32'(bus.active), 32'h1);
    repeat (4) cyc("t2_run");
    chk("t2_cycle4", 32'(bus.cycle), 32'h10);
    cyc("t2_wrap");
    chk("t2_wrap", 32'(bus.wrap), 32'h1);
    chk("t2_nodone", 32'(bus.done), 32'h0);
    repeat (6) cyc("t2_run");

    // 3: single pass, last=2
    bus.end_sig = 1'b1; cyc("t3_end"); bus.end_sig = 1'b0;
    bus.mode = 1'b1; bus.last = CW'(2);
    bus.begin_sig = 1'b1; cyc("t3_begin"); bus.begin_sig = 1'b0;
    repeat (3) cyc("t3_run");
    chk("t3_wrap", 32'(bus.wrap), 32'h1);
    chk("t3_done", 32'(bus.done), 32'h1);
    chk("t3_idle", 32'(bus.active), 32'h0);
    repeat (2) cyc("t3_rest");
    chk("t3_rest_cnt", 32'(bus.count), 32'h0);

    // 4: stall mid-sequence and at terminal
    bus.mode = 1'b0; bus.last = CW'(4);
    bus.begin_sig = 1'b1; cyc("t4_begin"); bus.begin_sig = 1'b0;
    seek(2);
    bus.stall = 1'b1; repeat (3) cyc("t4_stall");
    chk("t4_hold", 32'(bus.count), 32'h2);
    bus.stall = 1'b0; cyc("t4_resume");
    chk("t4_resume", 32'(bus.count), 32'h3);
    seek(4);
    bus.stall = 1'b1; repeat (3) cyc("t4_stall_term");
    chk("t4_nowrap", 32'(bus.wrap), 32'h0);
    bus.stall = 1'b0; cyc("t4_wrap");
    chk("t4_wrap", 32'(bus.wrap), 32'h1);

    // 5: begin+end together while running, then restart
    seek(3);
    bus.begin_sig = 1'b1; bus.end_sig = 1'b1; cyc("t5_both");
    bus.begin_sig = 1'b0; bus.end_sig = 1'b0;
    chk("t5_cnt", 32'(bus.count), 32'h3);
    chk("t5_done", 32'(bus.done), 32'h1);
    repeat (2) cyc("t5_idle");
    bus.begin_sig = 1'b1; cyc("t5_restart"); bus.begin_sig = 1'b0;
    chk("t5_restart", 32'(bus.count), 32'h0);
    cyc("t5_first");
    chk("t5_first", 32'(bus.count), 32'h1);

    // 6: lower last below count, then reset mid-run
    seek(4);
    bus.last = CW'(1); cyc("t6_shrink");
    chk("t6_wrap", 32'(bus.wrap), 32'h1);
    chk("t6_cnt", 32'(bus.count), 32'h0);
    repeat (3) cyc("t6_short");
    bus.last = CW'(4);
    seek(3);
    reset = 1'b0; cyc("t6_reset"); reset = 1'b1;
    chk("t6_rst_cnt", 32'(bus.count), 32'h0);
    chk("t6_rst_done", 32'(bus.done), 32'h0);

    // Random traffic, including out-of-range last values
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 49) != 0);
      bus.begin_sig = ($urandom_range(0, 4) == 0);
      bus.end_sig   = ($urandom_range(0, 11) == 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)  bus.last = CW'($urandom_range(0, 7));
      cyc("rand");
      chk("rand.onehot", 32'($onehot(bus.cycle)), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
